// File: rtl/spike_rate_avg.sv
// Sliding-window average of per-window spike counts with running peak.
// Sum over the last 2^LOG_DEPTH windows kept in a circular register buffer.
module spike_rate_avg #(
  parameter int CNT_W     = 32,
  parameter int LOG_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CNT_W-1:0]           cnt_in,
  input  logic                       cnt_valid,
  input  logic                       clear,
  output logic [CNT_W+LOG_DEPTH-1:0] sum_out,
  output logic [CNT_W-1:0]           rate_out,
  output logic [CNT_W-1:0]           peak_out,
  output logic                       rate_valid,
  output logic                       filled
);

  localparam int DEPTH  = 1 << LOG_DEPTH;
  localparam int SUM_W  = CNT_W + LOG_DEPTH;
  localparam int FILL_W = LOG_DEPTH + 1;

  logic [CNT_W-1:0]     hist_q [DEPTH];
  logic [CNT_W-1:0]     hist_d [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0]     rate_q, rate_d;
  logic [CNT_W-1:0]     peak_q, peak_d;
  logic                 rate_valid_q, rate_valid_d;
  logic                 filled_q, filled_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) hist_d[i] = hist_q[i];
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    sum_d        = sum_q;
    rate_d       = rate_q;
    peak_d       = peak_q;
    rate_valid_d = 1'b0;
    filled_d     = filled_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      sum_d      = '0;
      rate_d     = '0;
      peak_d     = '0;
      filled_d   = 1'b0;
    end else if (cnt_valid) begin
      // retire the oldest entry before adding, all at full sum width
      sum_d            = sum_q - SUM_W'(hist_q[wr_ptr_q])
                       + SUM_W'(cnt_in);
      hist_d[wr_ptr_q] = cnt_in;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (fill_cnt_q != FILL_W'(DEPTH))
        fill_cnt_d = fill_cnt_q + 1'b1;
      filled_d     = (fill_cnt_d == FILL_W'(DEPTH));
      rate_d       = CNT_W'(sum_d >> LOG_DEPTH);
      peak_d       = (rate_d > peak_q) ? rate_d : peak_q;
      rate_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      sum_q        <= '0;
      rate_q       <= '0;
      peak_q       <= '0;
      rate_valid_q <= 1'b0;
      filled_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      sum_q        <= sum_d;
      rate_q       <= rate_d;
      peak_q       <= peak_d;
      rate_valid_q <= rate_valid_d;
      filled_q     <= filled_d;
    end
  end

  assign sum_out    = sum_q;
  assign rate_out   = rate_q;
  assign peak_out   = peak_q;
  assign rate_valid = rate_valid_q;
  assign filled     = filled_q;

endmodule

// File: tb/tb_spike_rate_avg.sv
// Directed and randomized checks of spike_rate_avg against hand values
// and a sliding-window reference model.
module tb_spike_rate_avg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cnt_in;
  logic        cnt_valid;
  logic        clear;
  logic [34:0] sum_out;
  logic [31:0] rate_out;
  logic [31:0] peak_out;
  logic        rate_valid;
  logic        filled;

  int checks = 0;
  int errors = 0;

  spike_rate_avg #(.CNT_W(32), .LOG_DEPTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .clear      (clear),
    .sum_out    (sum_out),
    .rate_out   (rate_out),
    .peak_out   (peak_out),
    .rate_valid (rate_valid),
    .filled     (filled)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [34:0] s,
                         input logic [31:0] p, input logic rv,
                         input logic f);
    logic [34:0] r;
    r = s >> 3;
    chk({tag, "_sum"}, 64'(sum_out), 64'(s));
    chk({tag, "_rate"}, 64'(rate_out), 64'(r[31:0]));
    chk({tag, "_peak"}, 64'(peak_out), 64'(p));
    chk({tag, "_rv"}, 64'(rate_valid), 64'(rv));
    chk({tag, "_filled"}, 64'(filled), 64'(f));
  endtask

  logic [31:0] mh [8];
  logic [34:0] ms;
  logic [34:0] mr;
  logic [31:0] mp;
  int          mptr;
  int          mf;
  bit          clr;
  logic [31:0] v;
  logic [34:0] es;

  initial begin
    reset = 1'b1;
    cnt_valid = 1'b1;
    cnt_in = 32'd7;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 35'd0, 32'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    cnt_valid = 1'b0;
    tick();
    chk_all("idle", 35'd0, 32'd0, 1'b0, 1'b0);

    for (int k = 1; k <= 8; k++) begin
      cnt_valid = 1'b1;
      cnt_in = 32'd5;
      tick();
      cnt_valid = 1'b0;
      chk_all("fill", 35'(5 * k), 32'((5 * k) / 8), 1'b1, k == 8);
      tick();
      chk("fill_rv_off", 64'(rate_valid), 64'd0);
      repeat (8) tick();
      chk("fill_hold", 64'(sum_out), 64'(5 * k));
    end

    cnt_valid = 1'b1;
    cnt_in = 32'd13;
    tick();
    cnt_valid = 1'b0;
    chk_all("wrap13", 35'd48, 32'd6, 1'b1, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      cnt_valid = 1'b1;
      cnt_in = 32'd0;
      tick();
      cnt_valid = 1'b0;
      chk_all("drain", (j == 8) ? 35'd0 : 35'(48 - 5 * j),
              32'd6, 1'b1, 1'b1);
    end

    clear = 1'b1;
    cnt_valid = 1'b1;
    cnt_in = 32'd100;
    tick();
    clear = 1'b0;
    cnt_valid = 1'b0;
    chk_all("clrcol", 35'd0, 32'd0, 1'b0, 1'b0);
    cnt_valid = 1'b1;
    cnt_in = 32'd8;
    tick();
    cnt_valid = 1'b0;
    chk_all("after_clr", 35'd8, 32'd1, 1'b1, 1'b0);

    cnt_valid = 1'b1;
    cnt_in = 32'hFFFF_FFFF;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all("b2b",
              (i == 8) ? 35'h7_FFFF_FFF8
                       : 35'd8 + 35'(i) * 35'hFFFF_FFFF,
              (i == 8) ? 32'hFFFF_FFFF
                       : 32'((35'd8 + 35'(i) * 35'hFFFF_FFFF) >> 3),
              1'b1, i >= 7);
    end
    cnt_valid = 1'b0;
    tick();
    chk("b2b_rv_off", 64'(rate_valid), 64'd0);
    chk("b2b_hold", 64'(sum_out), 64'h7_FFFF_FFF8);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_all("pre_rand", 35'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) mh[i] = '0;
    mp = '0;
    mptr = 0;
    mf = 0;
    for (int n = 0; n < 2000; n++) begin
      clr = ($urandom_range(0, 99) == 0);
      v = $urandom;
      if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(0, 31);
      cnt_valid = 1'b1;
      cnt_in = v;
      clear = clr;
      tick();
      cnt_valid = 1'b0;
      clear = 1'b0;
      if (clr) begin
        for (int i = 0; i < 8; i++) mh[i] = '0;
        mp = '0;
        mptr = 0;
        mf = 0;
      end else begin
        mh[mptr] = v;
        mptr = (mptr + 1) % 8;
        if (mf < 8) mf++;
      end
      ms = '0;
      for (int i = 0; i < 8; i++) ms = ms + 35'(mh[i]);
      mr = ms >> 3;
      if (!clr && mr[31:0] > mp) mp = mr[31:0];
      chk_all("rand", ms, mp, !clr, mf == 8);
      if ($urandom_range(0, 3) == 0) begin
        es = ms;
        tick();
        chk("rand_idle_rv", 64'(rate_valid), 64'd0);
        chk("rand_idle_sum", 64'(sum_out), 64'(es));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
